// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared defaults and helpers for the fetch/prefetch unit.
//   ADDR_W_DEF   : PC / instruction-memory address width
//   INSTR_W_DEF  : instruction width
//   DEPTH_DEF    : prefetch queue entries (power of 2, >= 2)
//   RESET_PC_DEF : PC loaded on reset
//   PC_STEP_DEF  : PC increment per sequential fetch
package fetch_prefetch_unit_pkg;

    localparam int unsigned ADDR_W_DEF   = 64;
    localparam int unsigned INSTR_W_DEF  = 32;
    localparam int unsigned DEPTH_DEF    = 4;
    localparam int unsigned PC_STEP_DEF  = 4;
    localparam logic [63:0] RESET_PC_DEF = 64'h0;

    // Width of an occupancy counter that must hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response plus the
// decode-facing valid/ready stream.
//   master : the fetch unit (drives imem_req/imem_addr and the out_* stream)
//   slave  : memory + decode side (drives imem_rdata and out_ready)
interface fetch_prefetch_unit_if
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned INSTR_W = INSTR_W_DEF
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [ADDR_W-1:0]  out_pc;
    logic [INSTR_W-1:0] out_instr;

    modport master (
        output imem_req, imem_addr, out_valid, out_pc, out_instr,
        input  imem_rdata, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_pc, out_instr,
        output imem_rdata, out_ready
    );
endinterface

// File: rtl/fetch_prefetch_unit_fetch_fifo.sv
// Synchronous show-ahead FIFO for {pc, instr} entries.
//   clk, reset : clock, synchronous active-high reset
//   flush      : clears all entries (same effect as reset)
//   push/push_data : write one entry
//   pop        : retire the head entry
//   head_data  : current head entry (valid when count != 0)
//   count      : occupied entries, 0..DEPTH
module fetch_fifo
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int unsigned WIDTH = ADDR_W_DEF + INSTR_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              head_data,
    output logic [cnt_width(DEPTH)-1:0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset; count gates its visibility.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage with prefetch queue.
//   clk, reset  : clock, synchronous active-high reset
//   redirect    : flush + PC reload pulse, redirect_pc carries the new PC
//   bus         : master side of fetch_prefetch_unit_if (imem request/response
//                 and the valid/ready stream of {pc, instr} to decode)
//   fifo_count  : occupied prefetch entries
// One read per cycle is issued to a 1-cycle-latency memory as long as the queue
// plus the in-flight read leave room, so pushes can never overflow the queue.
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int unsigned        ADDR_W   = ADDR_W_DEF,
    parameter int unsigned        INSTR_W  = INSTR_W_DEF,
    parameter int unsigned        DEPTH    = DEPTH_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int unsigned        PC_STEP  = PC_STEP_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          redirect,
    input  logic [ADDR_W-1:0]             redirect_pc,
    fetch_prefetch_unit_if.master         bus,
    output logic [cnt_width(DEPTH)-1:0]   fifo_count
);
    localparam int unsigned CNT_W   = cnt_width(DEPTH);
    localparam int unsigned OCC_W   = CNT_W + 1;
    localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  inflight_pc;
    logic               inflight;
    logic               pop;
    logic               push;
    logic               issue;
    logic               valid;
    logic [OCC_W-1:0]   occ;
    logic [ENTRY_W-1:0] head;

    // Handshake and issue decisions; occ counts queued + in-flight - leaving.
    always_comb begin
        valid = (fifo_count != '0) && !redirect && !reset;
        pop   = valid && bus.out_ready;
        occ   = OCC_W'(fifo_count) + OCC_W'(inflight) - OCC_W'(pop);
        issue = !reset && !redirect && (occ < OCC_W'(DEPTH));
        push  = inflight && !redirect;
    end

    // PC and in-flight tracking; redirect drops the outstanding read.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect) begin
            pc          <= redirect_pc;
            inflight    <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= pc + ADDR_W'(PC_STEP);
                inflight_pc <= pc;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (push),
        .push_data ({inflight_pc, bus.imem_rdata}),
        .pop       (pop),
        .head_data (head),
        .count     (fifo_count)
    );

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc;
    assign bus.out_valid = valid;
    assign bus.out_pc    = head[ENTRY_W-1:INSTR_W];
    assign bus.out_instr = head[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: directed scenarios plus a
// randomized run checked against a stream-level reference model.
module tb_fetch_prefetch_unit;
    localparam int unsigned DEPTH = 4;
    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        ready = 1'b0;
    logic [2:0]  count1;
    logic [2:0]  count2;

    int total = 0;
    int bad   = 0;

    fetch_prefetch_unit_if #(.ADDR_W(64), .INSTR_W(32)) bus1 ();
    fetch_prefetch_unit_if #(.ADDR_W(64), .INSTR_W(32)) bus2 ();

    fetch_prefetch_unit #(.ADDR_W(64), .INSTR_W(32), .DEPTH(DEPTH),
                          .RESET_PC(64'h0), .PC_STEP(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus1),
        .fifo_count  (count1)
    );

    fetch_prefetch_unit #(.ADDR_W(64), .INSTR_W(32), .DEPTH(DEPTH),
                          .RESET_PC(WRAP_PC), .PC_STEP(4)) dut_wrap (
        .clk         (clk),
        .reset       (reset),
        .redirect    (1'b0),
        .redirect_pc (64'h0),
        .bus         (bus2),
        .fifo_count  (count2)
    );

    always #5 clk = ~clk;

    assign bus1.out_ready = ready;
    assign bus2.out_ready = 1'b1;

    // Instruction memory model: 1-cycle latency.
    always @(posedge clk) begin
        bus1.imem_rdata <= bus1.imem_addr[31:0] ^ 32'hA5A5_0000;
        bus2.imem_rdata <= bus2.imem_addr[31:0] ^ 32'hA5A5_0000;
    end

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'hA5A5_0000;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One reset cycle; the caller's next cycle is the release cycle.
    task automatic apply_reset();
        cyc();
        reset = 1'b1; redirect = 1'b0; ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (bus1.imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", bus1.imem_req); end
        total++; if (bus1.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus1.out_valid); end
        cyc();
        reset = 1'b1; redirect = 1'b1; redirect_pc = 64'h3000; ready = 1'b1;
        @(negedge clk);
        total++; if (count1 !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count1); end
        total++; if (bus1.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid2 got=%b exp=0", bus1.out_valid); end
        total++; if (bus1.imem_req !== 1'b0) begin bad++; $display("FAIL reset_req_redir got=%b exp=0", bus1.imem_req); end
    endtask

    task automatic test_stream();
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            cyc();
            reset = 1'b0; ready = 1'b1;
            @(negedge clk);
            total++; if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 64'(4 * k)) begin
                bad++; $display("FAIL stream_issue c=%0d got=%b/%h exp=1/%h", k, bus1.imem_req, bus1.imem_addr, 64'(4 * k)); end
            if (k < 2) begin
                total++; if (bus1.out_valid !== 1'b0) begin bad++; $display("FAIL stream_early_valid c=%0d got=%b exp=0", k, bus1.out_valid); end
            end else begin
                total++; if (bus1.out_valid !== 1'b1 || bus1.out_pc !== 64'(4 * (k - 2)) ||
                             bus1.out_instr !== mem_word(64'(4 * (k - 2)))) begin
                    bad++; $display("FAIL stream_pop c=%0d got=%b/%h/%h exp=1/%h/%h", k, bus1.out_valid,
                                    bus1.out_pc, bus1.out_instr, 64'(4 * (k - 2)), mem_word(64'(4 * (k - 2)))); end
            end
        end
    endtask

    task automatic test_stall();
        int nreq = 0;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            cyc();
            reset = 1'b0; ready = 1'b0;
            @(negedge clk);
            if (bus1.imem_req === 1'b1) begin
                total++; if (bus1.imem_addr !== 64'(4 * nreq)) begin
                    bad++; $display("FAIL stall_addr got=%h exp=%h", bus1.imem_addr, 64'(4 * nreq)); end
                nreq++;
            end
        end
        total++; if (nreq != 4) begin bad++; $display("FAIL stall_nreq got=%0d exp=4", nreq); end
        total++; if (bus1.imem_req !== 1'b0) begin bad++; $display("FAIL stall_req got=%b exp=0", bus1.imem_req); end
        total++; if (count1 !== 3'd4) begin bad++; $display("FAIL stall_count got=%0d exp=4", count1); end
        for (int k = 0; k < 8; k++) begin
            cyc();
            ready = 1'b1;
            @(negedge clk);
            total++; if (bus1.out_valid !== 1'b1 || bus1.out_pc !== 64'(4 * k) || bus1.out_instr !== mem_word(64'(4 * k))) begin
                bad++; $display("FAIL drain_pop c=%0d got=%b/%h exp=1/%h", k, bus1.out_valid, bus1.out_pc, 64'(4 * k)); end
            if (k == 0) begin
                total++; if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 64'h10) begin
                    bad++; $display("FAIL drain_resume got=%b/%h exp=1/10", bus1.imem_req, bus1.imem_addr); end
            end
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        for (int k = 0; k < 16; k++) begin
            cyc();
            reset = 1'b0; ready = 1'b1; redirect = (k == 10); redirect_pc = 64'h1000;
            @(negedge clk);
            if (k == 10) begin
                total++; if (bus1.out_valid !== 1'b0 || bus1.imem_req !== 1'b0) begin
                    bad++; $display("FAIL redir_cycle got valid=%b req=%b exp 0/0", bus1.out_valid, bus1.imem_req); end
            end
            if (k == 11) begin
                total++; if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 64'h1000) begin
                    bad++; $display("FAIL redir_issue got=%b/%h exp=1/1000", bus1.imem_req, bus1.imem_addr); end
            end
            if (k == 11 || k == 12) begin
                total++; if (bus1.out_valid !== 1'b0) begin bad++; $display("FAIL redir_bubble c=%0d got=%b exp=0", k, bus1.out_valid); end
            end
            if (k >= 13) begin
                total++; if (bus1.out_valid !== 1'b1 || bus1.out_pc !== 64'h1000 + 64'(4 * (k - 13))) begin
                    bad++; $display("FAIL redir_pop c=%0d got=%b/%h exp=1/%h", k, bus1.out_valid, bus1.out_pc, 64'h1000 + 64'(4 * (k - 13))); end
            end
        end
        redirect = 1'b0;
    endtask

    task automatic test_full_redirect();
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            cyc();
            reset = 1'b0; ready = 1'b0;
            @(negedge clk);
        end
        total++; if (count1 !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", count1); end
        cyc();
        redirect = 1'b1; redirect_pc = 64'h2000; ready = 1'b1;
        @(negedge clk);
        total++; if (bus1.out_valid !== 1'b0) begin bad++; $display("FAIL full_redir_valid got=%b exp=0", bus1.out_valid); end
        cyc();
        redirect = 1'b0; ready = 1'b0;
        @(negedge clk);
        total++; if (count1 !== 3'd0) begin bad++; $display("FAIL full_redir_count got=%0d exp=0", count1); end
    endtask

    task automatic test_wrap();
        logic [63:0] e;
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            cyc();
            reset = 1'b0;
            @(negedge clk);
            if (k >= 2) begin
                e = WRAP_PC + 64'(4 * (k - 2));
                total++; if (bus2.out_valid !== 1'b1 || bus2.out_pc !== e || bus2.out_instr !== mem_word(e)) begin
                    bad++; $display("FAIL wrap_pop c=%0d got=%b/%h/%h exp=1/%h/%h", k, bus2.out_valid, bus2.out_pc, bus2.out_instr, e, mem_word(e)); end
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            cyc();
            reset = 1'b0; ready = 1'b1;
            @(negedge clk);
        end
        cyc();
        reset = 1'b1; redirect = 1'b1; redirect_pc = 64'h2000;
        @(negedge clk);
        total++; if (bus1.imem_req !== 1'b0 || bus1.out_valid !== 1'b0) begin
            bad++; $display("FAIL mid_reset_outs got req=%b valid=%b exp 0/0", bus1.imem_req, bus1.out_valid); end
        cyc();
        reset = 1'b0; redirect = 1'b0;
        @(negedge clk);
        total++; if (count1 !== 3'd0 || bus1.out_valid !== 1'b0) begin
            bad++; $display("FAIL mid_reset_after got count=%0d valid=%b exp 0/0", count1, bus1.out_valid); end
        total++; if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 64'h0) begin
            bad++; $display("FAIL mid_reset_pc got=%b/%h exp=1/0", bus1.imem_req, bus1.imem_addr); end
        cyc(); @(negedge clk);
        cyc(); @(negedge clk);
        total++; if (bus1.out_valid !== 1'b1 || bus1.out_pc !== 64'h0) begin
            bad++; $display("FAIL mid_reset_first got=%b/%h exp=1/0", bus1.out_valid, bus1.out_pc); end
    endtask

    // Model: decode sees an arithmetic PC stream restarting at each flush, and
    // must see data no later than 3 cycles after the flush cycle.
    task automatic test_random();
        logic [63:0] exp_pop;
        logic [63:0] exp_iss;
        int          since;
        logic        r;
        logic        rd;
        logic [63:0] rpc;
        apply_reset();
        exp_pop = 64'h0;
        exp_iss = 64'h0;
        since   = 1;
        for (int k = 0; k < 800; k++) begin
            cyc();
            reset = 1'b0;
            rd  = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 24) == 0);
            rpc = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
            ready = rd; redirect = r; redirect_pc = rpc;
            @(negedge clk);
            if (r) begin
                total++; if (bus1.out_valid !== 1'b0 || bus1.imem_req !== 1'b0) begin
                    bad++; $display("FAIL rnd_redir c=%0d got valid=%b req=%b exp 0/0", k, bus1.out_valid, bus1.imem_req); end
                exp_pop = rpc;
                exp_iss = rpc;
                since   = 0;
            end else begin
                if (since >= 3) begin
                    total++; if (bus1.out_valid !== 1'b1) begin bad++; $display("FAIL rnd_bubble c=%0d got=%b exp=1", k, bus1.out_valid); end
                end
                if (bus1.out_valid === 1'b1 && rd) begin
                    total++; if (bus1.out_pc !== exp_pop || bus1.out_instr !== mem_word(exp_pop)) begin
                        bad++; $display("FAIL rnd_pop c=%0d got=%h/%h exp=%h/%h", k, bus1.out_pc, bus1.out_instr, exp_pop, mem_word(exp_pop)); end
                    exp_pop = exp_pop + 64'd4;
                end
                if (bus1.imem_req === 1'b1) begin
                    total++; if (bus1.imem_addr !== exp_iss) begin
                        bad++; $display("FAIL rnd_issue c=%0d got=%h exp=%h", k, bus1.imem_addr, exp_iss); end
                    exp_iss = exp_iss + 64'd4;
                end
            end
            total++; if (count1 > 3'(DEPTH)) begin bad++; $display("FAIL rnd_count c=%0d got=%0d max=%0d", k, count1, DEPTH); end
            since++;
        end
        redirect = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_full_redirect();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
